// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared edge- or center-aligned counter drives CHANNELS compare outputs.
// Duty, period and mode are double-buffered and only take effect at a period boundary.
module pwm_multi_ch #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int CH_BITS  = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    input  logic                mode,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_en,
    input  logic [CH_BITS-1:0]  wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [WIDTH-1:0]    r_cnt;
    dir_t                r_dir;
    logic [WIDTH-1:0]    r_period_act;
    logic                r_mode_act;
    logic [WIDTH-1:0]    r_shadow [CHANNELS];
    logic [WIDTH-1:0]    r_active [CHANNELS];

    logic [WIDTH-1:0]    w_cnt_next;
    dir_t                w_dir_next;
    logic                w_boundary;
    logic [CHANNELS-1:0] w_cmp;

    // Next count; a zero period always counts edge-style so the counter sits at 0.
    always_comb begin
        w_cnt_next = '0;
        w_dir_next = DIR_UP;
        if (en) begin
            if (!r_mode_act || (r_period_act == '0)) begin
                w_cnt_next = (r_cnt >= r_period_act) ? '0 : r_cnt + 1'b1;
            end else if (r_dir == DIR_UP) begin
                if (r_cnt >= r_period_act) begin
                    w_cnt_next = r_cnt - 1'b1;
                    w_dir_next = DIR_DOWN;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end else begin
                w_cnt_next = r_cnt - 1'b1;
                w_dir_next = DIR_DOWN;
            end
            if (w_cnt_next == '0) begin
                w_dir_next = DIR_UP;
            end
        end
    end

    // While disabled the next count is always 0, so settings reload every cycle.
    assign w_boundary = (w_cnt_next == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_dir <= DIR_UP;
        end else begin
            r_cnt <= w_cnt_next;
            r_dir <= w_dir_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (wr_en) begin
            r_shadow[wr_ch] <= wr_duty;
        end
    end

    // A write landing on the boundary edge bypasses the shadow and goes live at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_period_act <= '0;
            r_mode_act   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_active[i] <= '0;
            end
        end else if (w_boundary) begin
            r_period_act <= period;
            r_mode_act   <= mode;
            for (int i = 0; i < CHANNELS; i++) begin
                r_active[i] <= (wr_en && (wr_ch == CH_BITS'(i))) ? wr_duty : r_shadow[i];
            end
        end
    end

    always_comb begin
        w_cmp = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_cmp[i] = en && (r_cnt < r_active[i]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= w_cmp;
            period_start <= w_boundary && en;
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: a directed vector table of per-cycle inputs and expected outputs,
// plus hand-written asynchronous reset sequences.
`timescale 1ns/1ps
module tb_pwm_multi_ch;

    typedef struct {
        int         tid;
        logic       en;
        logic       mode;
        logic [7:0] period;
        logic       wr_en;
        logic [1:0] wr_ch;
        logic [7:0] wr_duty;
        logic [3:0] exp_pwm;
        logic       exp_ps;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] period = 8'd0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = 2'd0;
    logic [7:0] wr_duty = 8'd0;
    logic [3:0] pwm_out;
    logic       period_start;

    vec_t vecs[$];
    int   cur_tid = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pwm_multi_ch #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .en           (en),
        .mode         (mode),
        .period       (period),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    function automatic void add(input logic e, input logic m, input logic [7:0] p,
                                input logic w, input logic [1:0] c, input logic [7:0] d,
                                input logic [3:0] ep, input logic eps, input int n);
        vec_t v;
        v.tid = cur_tid; v.en = e; v.mode = m; v.period = p;
        v.wr_en = w; v.wr_ch = c; v.wr_duty = d;
        v.exp_pwm = ep; v.exp_ps = eps;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check_outputs(input string name, input int idx,
                                 input logic [3:0] ep, input logic eps);
        n_cmp++;
        if (pwm_out !== ep) begin
            n_fail++;
            $display("FAIL %s step %0d pwm_out: got %b, want %b", name, idx, pwm_out, ep);
        end
        n_cmp++;
        if (period_start !== eps) begin
            n_fail++;
            $display("FAIL %s step %0d period_start: got %b, want %b", name, idx, period_start, eps);
        end
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            en      = vecs[i].en;
            mode    = vecs[i].mode;
            period  = vecs[i].period;
            wr_en   = vecs[i].wr_en;
            wr_ch   = vecs[i].wr_ch;
            wr_duty = vecs[i].wr_duty;
            @(posedge clk);
            #1;
            check_outputs($sformatf("T%0d", vecs[i].tid), i, vecs[i].exp_pwm, vecs[i].exp_ps);
        end
        vecs.delete();
        wr_en = 1'b0;
    endtask

    initial begin
        // Power-on reset state
        #12;
        check_outputs("reset_init", 0, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // T1: configure while disabled, then edge mode P=9
        cur_tid = 1;
        add(0,0,9, 1,0,3,   4'b0000,0, 1);
        add(0,0,9, 1,1,0,   4'b0000,0, 1);
        add(0,0,9, 1,2,10,  4'b0000,0, 1);
        add(0,0,9, 1,3,255, 4'b0000,0, 1);
        add(1,0,9, 0,0,0,   4'b1101,0, 3);
        add(1,0,9, 0,0,0,   4'b1100,0, 6);
        add(1,0,9, 0,0,0,   4'b1100,1, 1);
        add(1,0,9, 0,0,0,   4'b1101,0, 3);
        add(1,0,9, 0,0,0,   4'b1100,0, 6);
        add(1,0,9, 0,0,0,   4'b1100,1, 1);
        // T2: ch0 duty 7 written at cnt=4, effective next period
        cur_tid = 2;
        add(1,0,9, 0,0,0,   4'b1101,0, 3);
        add(1,0,9, 0,0,0,   4'b1100,0, 1);
        add(1,0,9, 1,0,7,   4'b1100,0, 1);
        add(1,0,9, 0,0,0,   4'b1100,0, 4);
        add(1,0,9, 0,0,0,   4'b1100,1, 1);
        add(1,0,9, 0,0,0,   4'b1101,0, 7);
        add(1,0,9, 0,0,0,   4'b1100,0, 2);
        add(1,0,9, 0,0,0,   4'b1100,1, 1);
        add(1,0,9, 0,0,0,   4'b1101,0, 7);
        add(1,0,9, 0,0,0,   4'b1100,0, 2);
        // T3: ch1 duty 5 written on the boundary edge goes live immediately
        cur_tid = 3;
        add(1,0,9, 1,1,5,   4'b1100,1, 1);
        add(1,0,9, 0,0,0,   4'b1111,0, 5);
        add(1,0,9, 0,0,0,   4'b1101,0, 2);
        add(1,0,9, 0,0,0,   4'b1100,0, 2);
        add(1,0,9, 0,0,0,   4'b1100,1, 1);
        // T6: drop en at cnt=5, re-enable starts a fresh period
        cur_tid = 6;
        add(1,0,9, 0,0,0,   4'b1111,0, 5);
        add(0,0,9, 0,0,0,   4'b0000,0, 2);
        add(1,0,9, 0,0,0,   4'b1111,0, 5);
        add(1,0,9, 0,0,0,   4'b1101,0, 2);
        add(1,0,9, 0,0,0,   4'b1100,0, 2);
        add(1,0,9, 0,0,0,   4'b1100,1, 1);
        // T5: mode 0->1 and P 9->4 mid-period, edge period completes first
        cur_tid = 5;
        add(1,0,9, 0,0,0,   4'b1111,0, 2);
        add(1,1,4, 0,0,0,   4'b1111,0, 3);
        add(1,1,4, 0,0,0,   4'b1101,0, 2);
        add(1,1,4, 1,0,2,   4'b1100,0, 1);
        add(1,1,4, 1,1,1,   4'b1100,0, 1);
        add(1,1,4, 0,0,0,   4'b1100,1, 1);
        // T4: center mode P=4, ch0 duty 2 (3 cycles), ch1 duty 1 (1 cycle)
        cur_tid = 4;
        add(1,1,4, 0,0,0,   4'b1111,0, 1);
        add(1,1,4, 0,0,0,   4'b1101,0, 1);
        add(1,1,4, 0,0,0,   4'b1100,0, 5);
        add(1,1,4, 0,0,0,   4'b1101,1, 1);
        add(1,1,4, 0,0,0,   4'b1111,0, 1);
        add(1,1,4, 0,0,0,   4'b1101,0, 1);
        add(1,1,4, 0,0,0,   4'b1100,0, 5);
        add(1,1,4, 0,0,0,   4'b1101,1, 1);
        run_vecs();

        // Asynchronous reset mid-period: outputs clear without a clock edge
        #2;
        resetn = 1'b0;
        #1;
        check_outputs("async_reset", 0, 4'b0000, 1'b0);
        en = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("reset_hold", 0, 4'b0000, 1'b0);
        resetn = 1'b1;

        // T7: shadows cleared by reset; P=0 in both modes, then P=9
        cur_tid = 7;
        add(0,0,0, 1,2,1,   4'b0000,0, 1);
        add(1,0,0, 0,0,0,   4'b0100,1, 4);
        add(1,1,0, 0,0,0,   4'b0100,1, 2);
        add(1,0,9, 0,0,0,   4'b0100,1, 1);
        add(1,0,9, 0,0,0,   4'b0100,0, 1);
        add(1,0,9, 0,0,0,   4'b0000,0, 8);
        add(1,0,9, 0,0,0,   4'b0000,1, 1);
        run_vecs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Parametrised multi-channel PWM generator, the successor to the single-channel 4-bit PWM.
- One shared counter drives CHANNELS compare outputs.
- Programmable period; edge-aligned or center-aligned mode.
- Duty values are double-buffered so updates never glitch a running period.
- Sits beside the ALU in the top-level user design; configured from ui_in/uio_in, driving uo_out LEDs.

Parameters:
WIDTH, 8, bit width of counter, period and duty values
CHANNELS, 4, number of PWM outputs; power of two, >= 2
CH_BITS, log2(CHANNELS), width of channel select; derived, not overridden

Ports:
clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
en  input  1  run enable; 0 = counter held at 0, outputs low
mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled at boundary
period  input  WIDTH  top count value P; sampled at boundary
wr_en  input  1  write strobe for duty shadow register
wr_ch  input  CH_BITS  channel index for write
wr_duty  input  WIDTH  duty value to write
pwm_out  output  CHANNELS  registered PWM outputs
period_start  output  1  registered pulse, high for each cycle where cnt == 0 while running

Behaviour:
- Reset (resetn low, asynchronous; effective mid-operation):
  - cnt = 0, dir = up.
  - All shadow duty, active duty, period_act and mode_act registers = 0.
  - pwm_out = 0, period_start = 0.
- Write: on a clock edge with wr_en = 1, shadow[wr_ch] <= wr_duty. Writes are accepted regardless of en.
- Boundary: the clock edge on which the next cnt is 0 while en = 1.
  - period_act <= period; mode_act <= mode.
  - active[i] <= shadow[i].
  - Bypass: if wr_en is high on the boundary edge with wr_ch == i, active[i] <= wr_duty, i.e. the new value takes effect immediately.
- Edge-aligned counting (mode_act = 0):
  - cnt runs 0, 1, …, P, then 0; period is P+1 cycles.
  - P = 0: cnt stays 0, with a boundary every cycle.
- Center-aligned counting (mode_act = 1):
  - cnt runs 0 up to P, then down to 0 (dir toggles at P and at 0); period is 2P cycles.
  - P = 0: behaves as edge-aligned with P = 0.
- Compare: pwm_out[i] <= (cnt < active[i]), so pwm_out lags cnt by exactly 1 cycle.
  - Edge mode high time: min(d, P+1) cycles.
  - Center mode high time: 2d−1 cycles for 1 <= d <= P; constant high for d > P.
  - d = 0: constant low in both modes.
  - Unsigned compare throughout.
- period_start <= (next cnt == 0) && en, so it is high in the same cycle in which cnt == 0.
- en = 0:
  - cnt <= 0, dir <= up, pwm_out <= 0, period_start <= 0.
  - Active/period/mode registers reload from shadow and inputs every cycle, so the first running cycle after en rises starts a fresh period with current settings.
- A mode or period change mid-period has no effect until the next boundary.
- If period_act shrinks below the current cnt, this cannot occur, because period only loads at cnt == 0.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then en = 1, edge mode, P = 9, ch0 duty 3, ch1 duty 0, ch2 duty 10, ch3 duty 255 -> over a 10-cycle period: ch0 high 3 cycles, ch1 always low, ch2 and ch3 always high; period_start pulses every 10 cycles.
2. Edge mode P = 9, ch0 duty 3; write duty 7 at cnt = 4 -> current period keeps 3 high cycles; the following period has 7 high cycles, with no glitch.
3. Write ch1 duty 5 on the exact boundary edge (cnt = P) -> the new period immediately shows 5 high cycles (bypass).
4. Center mode P = 4, ch0 duty 2 -> cnt sequence 0,1,2,3,4,3,2,1 repeats; period 8 cycles, ch0 high 3 consecutive cycles around cnt = 0; period_start high once per 8 cycles.
5. Switch mode 0→1 and P 9→4 mid-period -> edge counting completes to 9, then center counting with P = 4 starts at the boundary.
6. Deassert en at cnt = 5 -> next cycle cnt = 0 and pwm_out = 0; reassert en -> a full fresh period starts. Then drop resetn asynchronously mid-period -> pwm_out and period_start go 0 without waiting for clk, and shadows read back 0 (outputs stay low).
